// File: rtl/wave_pwm_modulator_pkg.sv
// Shared types and constants for the wave-to-PWM modulator.
// Holds the FSM state encoding, the default sample width and the slot-count helper.
package pwm_pkg;

  localparam int WIDTH_DEF = 5;

  function automatic int cnt_max(input int w);
    return (1 << w) - 1;
  endfunction

  localparam int CNT_MAX = cnt_max(WIDTH_DEF);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_e;

endpackage

// File: rtl/wave_pwm_modulator_if.sv
// Sample/enable inputs and PWM status outputs of the modulator, bundled as one interface.
interface wave_pwm_modulator_if
  import pwm_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
);
  logic [WIDTH-1:0] wave;
  logic             en;
  logic             pwm_out;
  logic             period_start;
  logic [WIDTH-1:0] duty;
  logic             busy;

  modport master (output wave, en, input pwm_out, period_start, duty, busy);
  modport slave  (input wave, en, output pwm_out, period_start, duty, busy);
endinterface

// File: rtl/wave_pwm_modulator_prescaler.sv
// Slot-rate tick generator: one tick every PRESCALE clocks, held cleared while idle.
// With PRESCALE=1 the counter never leaves 0, so tick is constantly high.
module pwm_prescaler #(
  parameter int PRESCALE = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  output logic tick
);
  localparam logic [7:0] LAST = 8'(PRESCALE - 1);

  logic [7:0] pre_q, pre_d;

  always_comb begin
    pre_d = pre_q + 8'd1;
    if (clear || pre_q == LAST) pre_d = 8'd0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pre_q <= 8'd0;
    else        pre_q <= pre_d;
  end

  assign tick = (pre_q == LAST);
endmodule

// File: rtl/wave_pwm_modulator.sv
// Converts the free-running wave sample into a registered PWM bit.
// The duty value is latched only at period boundaries so a period never glitches.
module wave_pwm_modulator
  import pwm_pkg::*;
#(
  parameter int WIDTH    = WIDTH_DEF,
  parameter int PRESCALE = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  wave_pwm_modulator_if.slave  bus
);
  localparam logic [WIDTH-1:0] LAST_SLOT = WIDTH'(cnt_max(WIDTH));

  state_e           state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] duty_q, duty_d;
  logic             ps_q, ps_d;
  logic             pwm_q, pwm_d;
  logic             busy_q, busy_d;
  logic             tick;
  logic             wrap;

  pwm_prescaler #(.PRESCALE(PRESCALE)) u_prescaler (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (state_q == IDLE),
    .tick  (tick)
  );

  assign wrap = tick && (cnt_q == LAST_SLOT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      duty_q  <= '0;
      ps_q    <= 1'b0;
      pwm_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      duty_q  <= duty_d;
      ps_q    <= ps_d;
      pwm_q   <= pwm_d;
      busy_q  <= busy_d;
    end
  end

  // RUN and DRAIN differ only in what en does before the wrap; at the wrap en alone decides.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    duty_d  = duty_q;
    ps_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.en) begin
          state_d = RUN;
          cnt_d   = '0;
          duty_d  = bus.wave;
          ps_d    = 1'b1;
        end
      end
      RUN, DRAIN: begin
        if (wrap) begin
          cnt_d = '0;
          if (bus.en) begin
            state_d = RUN;
            duty_d  = bus.wave;
            ps_d    = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end else begin
          if (tick) cnt_d = cnt_q + WIDTH'(1);
          state_d = bus.en ? RUN : DRAIN;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output flops look at the next cycle's state, count and duty so they line up with them.
  always_comb begin
    pwm_d  = (state_d != IDLE) && (cnt_d < duty_d);
    busy_d = (state_d != IDLE);
  end

  assign bus.pwm_out      = pwm_q;
  assign bus.period_start = ps_q;
  assign bus.duty         = duty_q;
  assign bus.busy         = busy_q;
endmodule

// File: tb/tb_wave_pwm_modulator.sv
// Bench for wave_pwm_modulator: two instances (PRESCALE 1 and 3) driven identically,
// checked every clock against a period-level model plus table and hand-written sequences.
module tb_wave_pwm_modulator;
  logic clk;
  logic rst_n;

  wave_pwm_modulator_if #(.WIDTH(5)) b1 ();
  wave_pwm_modulator_if #(.WIDTH(5)) b3 ();

  wave_pwm_modulator #(.WIDTH(5), .PRESCALE(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(b1));
  wave_pwm_modulator #(.WIDTH(5), .PRESCALE(3)) dut3 (.clk(clk), .rst_n(rst_n), .bus(b3));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model: time within the current period in clocks, the latched duty, and whether active.
  int  psv [2] = '{1, 3};
  bit  m_act [2];
  int  m_t [2];
  int  m_duty [2];
  bit  m_ps [2];
  bit  en_r;
  logic [4:0] wave_r;

  typedef struct {
    logic [4:0] wave;
    int         dut;
    int         exp_high;
    int         exp_period;
  } vec_t;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int o_pwm(input int i);
    return (i == 0) ? int'(b1.pwm_out) : int'(b3.pwm_out);
  endfunction
  function automatic int o_ps(input int i);
    return (i == 0) ? int'(b1.period_start) : int'(b3.period_start);
  endfunction
  function automatic int o_busy(input int i);
    return (i == 0) ? int'(b1.busy) : int'(b3.busy);
  endfunction
  function automatic int o_duty(input int i);
    return (i == 0) ? int'(b1.duty) : int'(b3.duty);
  endfunction

  task automatic set_in(input bit e, input logic [4:0] w);
    en_r = e; wave_r = w;
    b1.en = e; b1.wave = w;
    b3.en = e; b3.wave = w;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_act[i] = 0; m_t[i] = 0; m_duty[i] = 0; m_ps[i] = 0;
    end
  endtask

  task automatic model_edge(input int i, input bit e, input int w);
    m_ps[i] = 0;
    if (!m_act[i]) begin
      if (e) begin
        m_act[i] = 1; m_t[i] = 0; m_duty[i] = w; m_ps[i] = 1;
      end
    end else begin
      m_t[i]++;
      if (m_t[i] == 32 * psv[i]) begin
        if (e) begin
          m_t[i] = 0; m_duty[i] = w; m_ps[i] = 1;
        end else begin
          m_act[i] = 0;
        end
      end
    end
  endtask

  task automatic step();
    bit e;
    int w;
    e = en_r;
    w = int'(wave_r);
    @(posedge clk);
    for (int i = 0; i < 2; i++) model_edge(i, e, w);
    #1;
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("pwm_out[ps%0d]", psv[i]), o_pwm(i),
          int'(m_act[i] && (m_t[i] / psv[i] < m_duty[i])));
      chk($sformatf("period_start[ps%0d]", psv[i]), o_ps(i), int'(m_ps[i]));
      chk($sformatf("busy[ps%0d]", psv[i]), o_busy(i), int'(m_act[i]));
      chk($sformatf("duty[ps%0d]", psv[i]), o_duty(i), m_duty[i]);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    set_in(1'b0, 5'd0);
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Assumes the current cycle shows period_start on instance i.
  task automatic measure_period(input int i, output int high, output int len);
    bit seen;
    high = o_pwm(i);
    len  = 0;
    seen = 0;
    for (int k = 0; k < 400 && !seen; k++) begin
      step();
      len++;
      if (o_ps(i) != 0) seen = 1;
      else high += o_pwm(i);
    end
    if (!seen) len = -1;
  endtask

  initial begin
    vec_t vecs [6];
    int hi, len, n, nps;

    vecs[0] = '{wave: 5'd10, dut: 0, exp_high: 10, exp_period: 32};
    vecs[1] = '{wave: 5'd0,  dut: 0, exp_high: 0,  exp_period: 32};
    vecs[2] = '{wave: 5'd31, dut: 0, exp_high: 31, exp_period: 32};
    vecs[3] = '{wave: 5'd1,  dut: 0, exp_high: 1,  exp_period: 32};
    vecs[4] = '{wave: 5'd4,  dut: 1, exp_high: 12, exp_period: 96};
    vecs[5] = '{wave: 5'd30, dut: 1, exp_high: 90, exp_period: 96};

    rst_n = 1'b0;
    set_in(1'b0, 5'd0);
    model_reset();
    @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      chk("reset pwm_out", o_pwm(i), 0);
      chk("reset busy", o_busy(i), 0);
      chk("reset duty", o_duty(i), 0);
      chk("reset period_start", o_ps(i), 0);
    end
    rst_n = 1'b1;
    step();

    // Table: duty and period length for one full period.
    for (int v = 0; v < 6; v++) begin
      do_reset();
      set_in(1'b1, vecs[v].wave);
      step();
      chk($sformatf("vec%0d first period_start", v), o_ps(vecs[v].dut), 1);
      measure_period(vecs[v].dut, hi, len);
      chk($sformatf("vec%0d high clocks", v), hi, vecs[v].exp_high);
      chk($sformatf("vec%0d period clocks", v), len, vecs[v].exp_period);
    end

    // Asynchronous reset mid-period while pwm_out is high.
    do_reset();
    set_in(1'b1, 5'd10);
    repeat (3) step();
    chk("pre-reset pwm_out", o_pwm(0), 1);
    rst_n = 1'b0;
    #2;
    model_reset();
    chk("async rst pwm_out", o_pwm(0), 0);
    chk("async rst busy", o_busy(0), 0);
    chk("async rst duty", o_duty(0), 0);
    chk("async rst period_start", o_ps(0), 0);
    set_in(1'b0, 5'd10);
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    repeat (4) step();
    chk("post-reset busy", o_busy(0), 0);

    // Wave changes mid-period are ignored until the next boundary.
    do_reset();
    set_in(1'b1, 5'd10);
    step();
    repeat (4) step();
    set_in(1'b1, 5'd20);
    hi = 5;
    n = 0;
    while (o_ps(0) == 0 && n < 100) begin
      step();
      n++;
      if (o_ps(0) == 0) hi += o_pwm(0);
    end
    chk("isolation first period high", hi, 10);
    measure_period(0, hi, len);
    chk("isolation second period high", hi, 20);

    // Drain: en dropped at slot 5 finishes the period then idles.
    do_reset();
    set_in(1'b1, 5'd7);
    step();
    repeat (5) step();
    set_in(1'b0, 5'd7);
    n = 0; nps = 0;
    for (int k = 0; k < 100; k++) begin
      step();
      n++;
      nps += o_ps(0);
      if (o_busy(0) == 0) break;
    end
    chk("drain clocks until idle", n, 27);
    repeat (40) begin
      step();
      nps += o_ps(0);
    end
    chk("drain period_start count", nps, 0);

    // Re-enable during drain: next period begins at the normal boundary.
    do_reset();
    set_in(1'b1, 5'd7);
    step();
    repeat (5) step();
    set_in(1'b0, 5'd7);
    repeat (15) step();
    set_in(1'b1, 5'd12);
    n = 20;
    for (int k = 0; k < 100; k++) begin
      step();
      n++;
      if (o_ps(0) != 0) break;
    end
    chk("re-enable period spacing", n, 32);
    chk("re-enable new duty", o_duty(0), 12);

    // Random run against the model, with occasional asynchronous resets.
    do_reset();
    for (int k = 0; k < 4000; k++) begin
      logic [4:0] w;
      bit e;
      w = 5'($urandom_range(0, 31));
      e = en_r;
      if ($urandom_range(0, 39) == 0) e = ~e;
      set_in(e, w);
      if ($urandom_range(0, 1499) == 0) begin
        do_reset();
      end
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
